// File: rtl/aud_timer.sv
// Elapsed-time counter driven by codec LRCK frames.
// Counts whole seconds in binary and BCD with run/pause/full control.
module aud_timer #(
  parameter int unsigned FRAMES_PER_SEC = 32000,
  parameter int unsigned MAX_SEC        = 59
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_lrc,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic       i_stop,
  output logic [5:0] o_sec,
  output logic [3:0] o_bcd_tens,
  output logic [3:0] o_bcd_ones,
  output logic       o_tick,
  output logic       o_running,
  output logic       o_paused,
  output logic       o_full
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    FULL
  } state_t;

  localparam logic [15:0] FRM_LAST = 16'(FRAMES_PER_SEC - 1);
  localparam logic [5:0]  SEC_MAX  = 6'(MAX_SEC);

  state_t      state;
  logic        sync1;
  logic        sync2;
  logic        hist;
  logic        frame_edge;
  logic [15:0] fcnt;
  logic [5:0]  sec_inc;

  assign frame_edge = sync2 & ~hist;
  assign sec_inc    = o_sec + 6'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      hist       <= 1'b0;
      fcnt       <= '0;
      o_sec      <= '0;
      o_bcd_tens <= '0;
      o_bcd_ones <= '0;
      o_tick     <= 1'b0;
      o_running  <= 1'b0;
      o_paused   <= 1'b0;
      o_full     <= 1'b0;
    end else begin
      sync1  <= i_lrc;
      sync2  <= sync1;
      hist   <= sync2;
      o_tick <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            state      <= RUN;
            o_running  <= 1'b1;
            fcnt       <= '0;
            o_sec      <= '0;
            o_bcd_tens <= '0;
            o_bcd_ones <= '0;
          end
        end
        RUN: begin
          if (i_stop) begin
            state     <= IDLE;
            o_running <= 1'b0;
          end else if (i_pause) begin
            state     <= PAUSE;
            o_running <= 1'b0;
            o_paused  <= 1'b1;
          end else if (frame_edge) begin
            if (fcnt == FRM_LAST) begin
              fcnt   <= '0;
              o_sec  <= sec_inc;
              o_tick <= 1'b1;
              // BCD tracks o_sec digit by digit with a decimal carry
              if (o_bcd_ones == 4'd9) begin
                o_bcd_ones <= 4'd0;
                o_bcd_tens <= o_bcd_tens + 4'd1;
              end else begin
                o_bcd_ones <= o_bcd_ones + 4'd1;
              end
              if (sec_inc == SEC_MAX) begin
                state     <= FULL;
                o_running <= 1'b0;
                o_full    <= 1'b1;
              end
            end else begin
              fcnt <= fcnt + 16'd1;
            end
          end
        end
        PAUSE: begin
          if (i_stop) begin
            state    <= IDLE;
            o_paused <= 1'b0;
          end else if (i_pause || i_start) begin
            state     <= RUN;
            o_paused  <= 1'b0;
            o_running <= 1'b1;
          end
        end
        FULL: begin
          if (i_stop) begin
            state  <= IDLE;
            o_full <= 1'b0;
          end else if (i_start) begin
            state      <= RUN;
            o_full     <= 1'b0;
            o_running  <= 1'b1;
            fcnt       <= '0;
            o_sec      <= '0;
            o_bcd_tens <= '0;
            o_bcd_ones <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aud_timer.sv
// Directed bench for aud_timer with FRAMES_PER_SEC=4, MAX_SEC=12.
// LRCK frames are 8 clocks: 4 high, 4 low.
module tb_aud_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       lrc;
  logic       start;
  logic       pause;
  logic       stop;
  logic [5:0] sec;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       tick;
  logic       running;
  logic       paused;
  logic       full;

  int n_chk  = 0;
  int n_fail = 0;

  int cyc_n     = 0;
  int tick_cnt  = 0;
  int wide_err  = 0;
  int lat_err   = 0;
  int bcd_err   = 0;
  int last_rise = 0;
  logic lrc_q   = 1'b0;
  logic tick_q  = 1'b0;
  int t0;

  aud_timer #(
    .FRAMES_PER_SEC(4),
    .MAX_SEC(12)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_lrc(lrc),
    .i_start(start),
    .i_pause(pause),
    .i_stop(stop),
    .o_sec(sec),
    .o_bcd_tens(tens),
    .o_bcd_ones(ones),
    .o_tick(tick),
    .o_running(running),
    .o_paused(paused),
    .o_full(full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    lrc_q  <= lrc;
    tick_q <= tick;
    if (lrc && !lrc_q) last_rise <= cyc_n;
    if (tick) tick_cnt <= tick_cnt + 1;
    if (tick && tick_q) wide_err <= wide_err + 1;
    if (tick && (cyc_n - last_rise != 3)) lat_err <= lat_err + 1;
    if (int'(tens) * 10 + int'(ones) != int'(sec)) bcd_err <= bcd_err + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    lrc = 1'b1;
    repeat (4) cyc();
    lrc = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic p_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic p_pause();
    pause = 1'b1;
    cyc();
    pause = 1'b0;
  endtask

  task automatic p_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    rst   = 1'b1;
    lrc   = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    stop  = 1'b0;
    cyc();
    cyc();
    chk("rst_sec", int'(sec), 0);
    chk("rst_bcd", int'({tens, ones}), 0);
    chk("rst_flags", int'({tick, running, paused, full}), 0);
    rst = 1'b0;
    cyc();

    // 40 frames -> 10 seconds
    p_start();
    chk("start_run", int'(running), 1);
    chk("start_sec", int'(sec), 0);
    t0 = tick_cnt;
    frames(40);
    chk("r40_sec", int'(sec), 10);
    chk("r40_tens", int'(tens), 1);
    chk("r40_ones", int'(ones), 0);
    chk("r40_ticks", tick_cnt - t0, 10);
    chk("r40_width", wide_err, 0);
    chk("r40_latency", lat_err, 0);

    p_stop();
    chk("stop_run", int'(running), 0);
    chk("stop_hold", int'(sec), 10);
    p_pause();
    chk("idle_pause_ign", int'(paused), 0);

    // pause window
    p_start();
    frames(6);
    chk("p6_sec", int'(sec), 1);
    chk("p6_notpaused", int'(paused), 0);
    p_pause();
    chk("pz_paused", int'(paused), 1);
    chk("pz_run", int'(running), 0);
    t0 = tick_cnt;
    frames(20);
    chk("pz_sec", int'(sec), 1);
    chk("pz_ticks", tick_cnt - t0, 0);
    chk("pz_still", int'(paused), 1);
    p_pause();
    chk("resume_pause", int'(paused), 0);
    chk("resume_run", int'(running), 1);
    frames(2);
    chk("p2_sec", int'(sec), 2);

    // saturation at MAX_SEC
    p_stop();
    p_start();
    frames(47);
    chk("f47_sec", int'(sec), 11);
    chk("f47_full", int'(full), 0);
    frame();
    chk("f48_sec", int'(sec), 12);
    chk("f48_bcd", int'({tens, ones}), 8'h12);
    chk("f48_full", int'(full), 1);
    chk("f48_run", int'(running), 0);
    frames(12);
    chk("f60_sec", int'(sec), 12);
    p_pause();
    chk("full_pause_ign", int'({paused, full}), 1);
    p_start();
    chk("full_start_sec", int'(sec), 0);
    chk("full_start_run", int'({running, full}), 2);
    chk("full_start_bcd", int'({tens, ones}), 0);

    // all commands together with a qualifying frame edge
    frames(7);
    chk("c7_sec", int'(sec), 1);
    t0 = tick_cnt;
    lrc = 1'b1;
    cyc();
    cyc();
    stop  = 1'b1;
    pause = 1'b1;
    start = 1'b1;
    cyc();
    stop  = 1'b0;
    pause = 1'b0;
    start = 1'b0;
    chk("all_cmd_state", int'({running, paused, full}), 0);
    chk("all_cmd_sec", int'(sec), 1);
    repeat (1) cyc();
    lrc = 1'b0;
    repeat (4) cyc();
    chk("all_cmd_ticks", tick_cnt - t0, 0);
    chk("all_cmd_sec2", int'(sec), 1);

    // reset mid-second
    p_start();
    frames(23);
    chk("m23_sec", int'(sec), 5);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mrst_sec", int'(sec), 0);
    chk("mrst_bcd", int'({tens, ones}), 0);
    chk("mrst_flags", int'({tick, running, paused, full}), 0);
    t0 = tick_cnt;
    frames(8);
    chk("mrst_idle_sec", int'(sec), 0);
    chk("mrst_idle_ticks", tick_cnt - t0, 0);
    p_start();
    frames(4);
    chk("mrst_restart", int'(sec), 1);

    // phase shifts: one delayed edge, one merged high period
    p_stop();
    p_start();
    frames(10);
    lrc = 1'b1;
    repeat (4) cyc();
    lrc = 1'b0;
    repeat (8) cyc();
    frames(5);
    lrc = 1'b1;
    repeat (8) cyc();
    lrc = 1'b0;
    repeat (4) cyc();
    frames(4);
    chk("ph_sec", int'(sec), 5);
    chk("ph_bcd", int'({tens, ones}), 8'h05);
    chk("ph_bcd_cons", bcd_err, 0);
    chk("ph_width", wide_err, 0);
    chk("ph_latency", lat_err, 0);

    // reset while FULL
    p_stop();
    p_start();
    frames(48);
    chk("rf_full", int'(full), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rf_sec", int'(sec), 0);
    chk("rf_flags", int'({tick, running, paused, full}), 0);
    chk("end_bcd_cons", bcd_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
